// File: rtl/andnot_pkg.sv
// Shared definitions for the and-not event capture block: FSM state encoding
// and the saturating counter helper.
package andnot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRIP  = 2'd2
    } state_e;

    // Increments v but never wraps past the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned width);
        logic [31:0] maxVal;
        maxVal = (32'h1 << width) - 32'h1;
        return (v >= maxVal) ? maxVal : v + 32'h1;
    endfunction

endpackage

// File: rtl/andnot_hit_gen.sv
// Per-channel hit detection: raw = a & ~b, optionally reduced to rising edges
// of raw using a history register that updates every cycle.
module andnot_hit_gen
    import andnot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit EDGE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hit
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] prev_q;

    assign raw = a & ~b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= raw;
        end
    end

    assign hit = EDGE ? (raw & ~prev_q) : raw;

endmodule

// File: rtl/andnot_event_capture.sv
// Registered a & ~b event capture: sticky per-channel status, saturating
// hit-cycle counter, threshold trip with irq, and a clear-on-read snapshot port.
module andnot_event_capture
    import andnot_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 4,
    parameter bit EDGE   = 1'b0,
    parameter int THRESH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             irq,
    output logic             armed
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] status_q,   status_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;

    logic [WIDTH-1:0] hit;
    logic             any;
    logic [CNT_W-1:0] cnt_inc;

    andnot_hit_gen #(
        .WIDTH (WIDTH),
        .EDGE  (EDGE)
    ) u_hit_gen (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .hit   (hit)
    );

    assign any     = |hit;
    assign cnt_inc = CNT_W'(sat_inc(32'(cnt_q), CNT_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            status_q   <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // A read always snapshots the pre-edge status; what happens to status
    // afterwards depends on the state, with ARMED reloading it from this
    // cycle's hits so nothing arriving alongside the read is lost.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? status_q : rd_data_q;

        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    status_d = '0;
                    cnt_d    = '0;
                end
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!arm) begin
                    state_d = IDLE;
                    if (rd_req) begin
                        status_d = '0;
                        cnt_d    = '0;
                    end
                end else begin
                    if (rd_req) begin
                        status_d = hit;
                        cnt_d    = CNT_W'(any);
                    end else begin
                        status_d = status_q | hit;
                        if (any) begin
                            cnt_d = cnt_inc;
                        end
                    end
                    if (any && (cnt_d >= THRESH_C)) begin
                        state_d = TRIP;
                    end
                end
            end
            TRIP: begin
                if (rd_req) begin
                    status_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign hit_cnt  = cnt_q;
    assign irq      = (state_q == TRIP);
    assign armed    = (state_q == ARMED);

endmodule

// File: tb/tb_andnot_event_capture.sv
// Directed self-checking bench: four instances with different parameter sets,
// each driven through hand-computed sequences.
module tb_andnot_event_capture;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    // Instance 1: WIDTH=1, THRESH=1
    logic       arm1, a1, b1, rd1, rv1, rdat1, irq1, armd1;
    logic [3:0] cnt1;

    // Instance 8: WIDTH=8, THRESH=3
    logic       arm8, rd8, rv8, irq8, armd8;
    logic [7:0] a8, b8, rdat8;
    logic [3:0] cnt8;

    // Instance E: EDGE=1, THRESH=15
    logic       armE, rdE, rvE, irqE, armdE;
    logic [7:0] aE, bE, rdatE;
    logic [3:0] cntE;

    // Instance S: CNT_W=2, THRESH=3
    logic       armS, rdS, rvS, irqS, armdS;
    logic [7:0] aS, bS, rdatS;
    logic [1:0] cntS;

    andnot_event_capture #(.WIDTH(1), .CNT_W(4), .EDGE(1'b0), .THRESH(1)) u1 (
        .clk(clk), .reset(reset), .arm(arm1), .a(a1), .b(b1), .rd_req(rd1),
        .rd_valid(rv1), .rd_data(rdat1), .hit_cnt(cnt1), .irq(irq1), .armed(armd1));

    andnot_event_capture #(.WIDTH(8), .CNT_W(4), .EDGE(1'b0), .THRESH(3)) u8 (
        .clk(clk), .reset(reset), .arm(arm8), .a(a8), .b(b8), .rd_req(rd8),
        .rd_valid(rv8), .rd_data(rdat8), .hit_cnt(cnt8), .irq(irq8), .armed(armd8));

    andnot_event_capture #(.WIDTH(8), .CNT_W(4), .EDGE(1'b1), .THRESH(15)) uE (
        .clk(clk), .reset(reset), .arm(armE), .a(aE), .b(bE), .rd_req(rdE),
        .rd_valid(rvE), .rd_data(rdatE), .hit_cnt(cntE), .irq(irqE), .armed(armdE));

    andnot_event_capture #(.WIDTH(8), .CNT_W(2), .EDGE(1'b0), .THRESH(3)) uS (
        .clk(clk), .reset(reset), .arm(armS), .a(aS), .b(bS), .rd_req(rdS),
        .rd_valid(rvS), .rd_data(rdatS), .hit_cnt(cntS), .irq(irqS), .armed(armdS));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges and settle just after the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        arm1 = 0; a1 = 0; b1 = 0; rd1 = 0;
        arm8 = 0; a8 = 0; b8 = 0; rd8 = 0;
        armE = 0; aE = 0; bE = 0; rdE = 0;
        armS = 0; aS = 0; bS = 0; rdS = 0;

        applyStimulus(2);
        checkOutput("rst_rv",    32'(rv8),   0);
        checkOutput("rst_rdata", 32'(rdat8), 0);
        checkOutput("rst_cnt",   32'(cnt8),  0);
        checkOutput("rst_irq",   32'(irq8),  0);
        checkOutput("rst_armed", 32'(armd8), 0);
        reset = 1'b0;

        // T1: a & ~b is never true with b=1
        arm1 = 1; a1 = 1; b1 = 1;
        applyStimulus(4);
        checkOutput("t1_cnt",   32'(cnt1),  0);
        checkOutput("t1_irq",   32'(irq1),  0);
        checkOutput("t1_armed", 32'(armd1), 1);
        rd1 = 1;
        applyStimulus(1);
        rd1 = 0;
        checkOutput("t1_rv",    32'(rv1),   1);
        checkOutput("t1_rdata", 32'(rdat1), 0);
        applyStimulus(1);
        checkOutput("t1_rv_drop", 32'(rv1), 0);

        // T2: hit = F0 & ~30 = C0, trip on third hit cycle
        arm8 = 1; a8 = 8'hF0; b8 = 8'h30;
        applyStimulus(2);
        checkOutput("t2_cnt1",  32'(cnt8), 1);
        checkOutput("t2_irq0",  32'(irq8), 0);
        applyStimulus(2);
        checkOutput("t2_cnt3",  32'(cnt8), 3);
        checkOutput("t2_irq1",  32'(irq8), 1);
        checkOutput("t2_armed", 32'(armd8), 0);

        // T3: frozen in TRIP, then read clears and returns to IDLE
        a8 = 8'h0F; b8 = 8'h00; arm8 = 0;
        applyStimulus(2);
        checkOutput("t3_cnt_frozen", 32'(cnt8), 3);
        checkOutput("t3_irq_held",   32'(irq8), 1);
        rd8 = 1;
        applyStimulus(1);
        rd8 = 0;
        checkOutput("t3_rv",    32'(rv8),   1);
        checkOutput("t3_rdata", 32'(rdat8), 8'hC0);
        checkOutput("t3_irq",   32'(irq8),  0);
        checkOutput("t3_armed", 32'(armd8), 0);
        checkOutput("t3_cnt",   32'(cnt8),  0);
        applyStimulus(1);
        checkOutput("t3_rv_drop", 32'(rv8), 0);

        // T4: read in ARMED with a simultaneous hit
        arm8 = 1; a8 = 8'h01; b8 = 8'h00;
        applyStimulus(2);
        checkOutput("t4_cnt_pre", 32'(cnt8), 1);
        a8 = 8'h02; rd8 = 1;
        applyStimulus(1);
        checkOutput("t4_rv",    32'(rv8),   1);
        checkOutput("t4_rdata", 32'(rdat8), 8'h01);
        checkOutput("t4_cnt",   32'(cnt8),  1);
        checkOutput("t4_armed", 32'(armd8), 1);
        rd8 = 0; a8 = 8'h00;
        applyStimulus(1);
        checkOutput("t4_rv_drop",  32'(rv8),   0);
        checkOutput("t4_rdata_hold", 32'(rdat8), 8'h01);
        rd8 = 1;
        applyStimulus(1);
        rd8 = 0;
        checkOutput("t4_rdata2", 32'(rdat8), 8'h02);
        checkOutput("t4_cnt2",   32'(cnt8),  0);

        // Disarm retains status and count; a later IDLE read returns them
        a8 = 8'h04;
        applyStimulus(1);
        arm8 = 0; a8 = 8'h08;
        applyStimulus(2);
        checkOutput("ret_armed", 32'(armd8), 0);
        checkOutput("ret_cnt",   32'(cnt8),  1);
        rd8 = 1;
        applyStimulus(1);
        rd8 = 0;
        checkOutput("ret_rdata", 32'(rdat8), 8'h04);
        checkOutput("ret_cnt0",  32'(cnt8),  0);

        // T5: edge mode counts only the 0->1 transitions
        armE = 1;
        applyStimulus(1);
        aE = 8'h01;
        applyStimulus(4);
        checkOutput("t5_cnt1", 32'(cntE), 1);
        aE = 8'h00;
        applyStimulus(1);
        aE = 8'h01;
        applyStimulus(1);
        checkOutput("t5_cnt2", 32'(cntE), 2);

        // T6: narrow counter stops at 3, then reset lands during a read
        armS = 1; aS = 8'hFF; bS = 8'h00;
        applyStimulus(3);
        checkOutput("t6_cnt2", 32'(cntS), 2);
        checkOutput("t6_irq0", 32'(irqS), 0);
        applyStimulus(3);
        checkOutput("t6_cnt3", 32'(cntS), 3);
        checkOutput("t6_irq1", 32'(irqS), 1);
        rdS = 1;
        applyStimulus(1);
        checkOutput("t6_rv",    32'(rvS),   1);
        checkOutput("t6_rdata", 32'(rdatS), 8'hFF);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_rv",    32'(rvS),   0);
        checkOutput("t6_rst_rdata", 32'(rdatS), 0);
        checkOutput("t6_rst_cnt",   32'(cntS),  0);
        checkOutput("t6_rst_irq",   32'(irqS),  0);
        checkOutput("t6_rst_armed", 32'(armdS), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
